instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the instruction memory. Owns the PC and drives the word address into the combinational imem.
//  Captures returned words into a small prefetch FIFO and hands {pc, instr} to decode over a valid/ready handshake.
//  Handles redirects (branch/jump), halt requests and out-of-range/misaligned fetch faults.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  IMEM_WORDS  1024           imem depth in words; pc[31:2] >= IMEM_WORDS is out of range
//  FIFO_DEPTH  2              prefetch entries, power of two, >= 2
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   synchronous, active-high
//  imem_addr      out  32  byte address to imem (imem uses addr[31:2]), = fetch PC
//  imem_rdata     in   32  instruction word, valid same cycle as imem_addr
//  if_valid       out  1   FIFO head valid
//  if_pc          out  32  PC of head entry
//  if_instr       out  32  instruction of head entry
//  if_ready       in   1   decode accepts head when if_valid & if_ready
//  redirect_valid in   1   flush and refetch from redirect_pc
//  redirect_pc    in   32  new fetch PC
//  halt_req       in   1   level: stop issuing new fetches while high
//  fetch_fault    out  1   sticky fault flag, cleared by reset or valid redirect
//  fault_pc       out  32  PC that faulted
// BEHAVIOUR
//  Reset: fetch PC=RESET_PC, FIFO empty, if_valid=0, if_pc=0, if_instr=0, fetch_fault=0, fault_pc=0, state=BOOT.
//  States: BOOT -> RUN (1 cycle, no fetch). RUN -> HALT when halt_req; HALT -> RUN when !halt_req.
//    RUN/HALT -> FAULT on fault condition. FAULT -> RUN only on redirect with valid target.
//  Fetch (RUN only): if FIFO not full after this cycle's pop, push {pc, imem_rdata}; pc += 4.
//    Full FIFO with simultaneous pop counts as not full (push and pop same cycle allowed).
//  Throughput 1 instr/cycle; latency fetch->if_valid 1 cycle (FIFO registered, no bypass).
//  Handshake: if_pc/if_instr stable while if_valid & !if_ready; pop only on if_valid & if_ready.
//  Redirect (any state except BOOT): FIFO flushed same cycle (pop ignored, no push); pc<=redirect_pc;
//    if_valid=0 next cycle. Redirect wins over halt_req and over pending fetch.
//  Fault: redirect_pc[1:0]!=0 or redirect_pc[31:2]>=IMEM_WORDS -> FAULT, fetch_fault=1,
//    fault_pc=redirect_pc. Sequential pc stepping to pc[31:2]==IMEM_WORDS -> FAULT, fault_pc=that pc.
//    In FAULT: no fetches; already-queued entries still drain to decode.
//  PC arithmetic 32-bit, wraps modulo 2^32 (out-of-range fault triggers first for IMEM_WORDS<2^30).
//  Reset mid-operation overrides everything: state, FIFO, outputs return to reset values next edge.
// CONFIGURATION
//  FETCH_STATS_EN defined: adds out ports fetch_cnt[31:0] (pushes), stall_cnt[31:0] (cycles
//    if_valid & !if_ready), redirect_cnt[31:0]; all reset to 0, wrap at 2^32.
//  Not defined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Shared package (riscv_pkg): fetch state encoding (BOOT, RUN, HALT, FAULT), RESET_PC default, INSTR_W=32.
//  Sub-module: fetch_fifo (sync FIFO, push/pop/flush, full/empty, DEPTH param) instantiated once.
//  Top holds PC register, FSM, fault logic, optional counters.
// TESTING
//  Reset, if_ready=1, imem preloaded mem[0..4] -> if_pc 0,4,8,C,10 on consecutive cycles from cycle 2, instr match words.
//  Hold if_ready=0 5 cycles -> FIFO fills (2 entries), pc stops at 8, head pc=0 stable; release -> 0,4,8 in order, no drop.
//  Redirect to 0x10 while FIFO holds pc 4,8 -> next if_valid pc=0x10, entries 4,8 never presented.
//  Redirect to 0x0000_0006 -> fetch_fault=1, fault_pc=6, no fetch; redirect to 0x0 -> fault clear, fetch resumes at 0.
//  Run to pc 0xFFC with IMEM_WORDS=1024 -> pc 0x1000 faults, fault_pc=0x1000, last delivered pc=0xFFC.
//  halt_req high 3 cycles mid-stream, then reset asserted mid-halt -> no fetches during halt; after reset fetch from RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side types: FSM state encoding, FIFO entry layout and the
// address range check used for both redirect targets and sequential PCs.
package riscv_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // True when the byte address is misaligned or its word index is past imem.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= words);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO with flush; read data is the head entry,
// valid only while not empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

    // Storage carries no reset; the top masks head data while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_reg] <= wdata;
    end

    assign rdata = mem[rd_ptr_reg];
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: PC, fetch FSM, fault tracking, prefetch FIFO.
// Define FETCH_STATS_EN to add fetch/stall/redirect counter ports.
module instr_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = 1024,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               if_ready,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               halt_req,
    output logic               fetch_fault,
    output logic [31:0]        fault_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        redirect_cnt
`endif
);
    localparam logic [31:0] WORDS = 32'(IMEM_WORDS);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         fault_reg, fault_next;
    logic [31:0]  fault_pc_reg, fault_pc_next;

    logic         redirect_take, redirect_bad, seq_fault;
    logic         push, pop, full, empty;
    fetch_entry_t wr_entry, head_entry;

    assign redirect_take = redirect_valid && (state_reg != ST_BOOT);
    assign redirect_bad  = addr_bad(redirect_pc, WORDS);
    assign seq_fault     = !redirect_take && (state_reg inside {ST_RUN, ST_HALT})
                           && addr_bad(pc_reg, WORDS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_PC;
            fault_reg    <= 1'b0;
            fault_pc_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            fault_reg    <= fault_next;
            fault_pc_reg <= fault_pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_BOOT)
            state_next = ST_RUN;
        else if (redirect_take)
            state_next = redirect_bad ? ST_FAULT : ST_RUN;
        else if (seq_fault)
            state_next = ST_FAULT;
        else if (state_reg == ST_RUN && halt_req)
            state_next = ST_HALT;
        else if (state_reg == ST_HALT && !halt_req)
            state_next = ST_RUN;
    end

    // Redirect flushes the FIFO, so a pop in that cycle is dropped with it.
    always_comb begin
        pop           = !empty && if_ready && !redirect_take;
        push          = (state_reg == ST_RUN) && !halt_req && !redirect_take
                        && !seq_fault && (!full || pop);
        pc_next       = pc_reg;
        fault_next    = fault_reg;
        fault_pc_next = fault_pc_reg;
        if (redirect_take) begin
            pc_next    = redirect_pc;
            fault_next = redirect_bad;
            if (redirect_bad) fault_pc_next = redirect_pc;
        end else if (seq_fault) begin
            fault_next    = 1'b1;
            fault_pc_next = pc_reg;
        end else if (push) begin
            pc_next = pc_reg + 32'd4;
        end
    end

    assign wr_entry.pc    = pc_reg;
    assign wr_entry.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_take),
        .wdata (wr_entry),
        .rdata (head_entry),
        .full  (full),
        .empty (empty)
    );

    assign imem_addr   = pc_reg;
    assign if_valid    = !empty;
    assign if_pc       = empty ? '0 : head_entry.pc;
    assign if_instr    = empty ? '0 : head_entry.instr;
    assign fetch_fault = fault_reg;
    assign fault_pc    = fault_pc_reg;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_reg, stall_cnt_reg, redirect_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_reg    <= '0;
            stall_cnt_reg    <= '0;
            redirect_cnt_reg <= '0;
        end else begin
            if (push)                 fetch_cnt_reg    <= fetch_cnt_reg + 1'b1;
            if (if_valid && !if_ready) stall_cnt_reg   <= stall_cnt_reg + 1'b1;
            if (redirect_take)        redirect_cnt_reg <= redirect_cnt_reg + 1'b1;
        end
    end

    assign fetch_cnt    = fetch_cnt_reg;
    assign stall_cnt    = stall_cnt_reg;
    assign redirect_cnt = redirect_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: imem word at index i is 0x1300_0000 | i.
module tb_instr_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        fetch_fault;
    logic [31:0] fault_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt, stall_cnt, redirect_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr[31:12] == 20'd0) ? (32'h1300_0000 | {22'd0, imem_addr[11:2]})
                                                    : 32'hDEAD_BEEF;

    instr_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt),
        .redirect_cnt   (redirect_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; halt_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_pc); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", if_instr); end
        checks++; if (fetch_fault !== 1'b0 || fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault got %b/%h exp 0/0", fetch_fault, fault_pc); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    endtask

    task automatic test_stream();
        if_ready = 1'b1;
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL boot_no_fetch got %b exp 0", if_valid); end
        for (int k = 0; k < 5; k++) begin
            tick();
            $display("txn stream pc=%h instr=%h valid=%b", if_pc, if_instr, if_valid);
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4*k)) begin errors++; $display("FAIL stream_pc got %b/%h exp 1/%h", if_valid, if_pc, 32'(4*k)); end
            checks++; if (if_instr !== (32'h1300_0000 | 32'(k))) begin errors++; $display("FAIL stream_instr got %h exp %h", if_instr, 32'h1300_0000 | 32'(k)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tick();
        if_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL hold_head got %b/%h exp 1/0", if_valid, if_pc); end
        end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL hold_pc got %h exp 8", imem_addr); end
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            $display("txn release pc=%h instr=%h", if_pc, if_instr);
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4*k)) begin errors++; $display("FAIL release_order got %b/%h exp 1/%h", if_valid, if_pc, 32'(4*k)); end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        tick();
        tick(); tick();
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL pre_redirect_head got %h exp 4", if_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h10; if_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        $display("txn redirect to %h", 32'h10);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redirect_flush got %b exp 0", if_valid); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL redirect_addr got %h exp 10", imem_addr); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== 32'h1300_0004) begin errors++; $display("FAIL redirect_first got %b/%h/%h exp 1/10/13000004", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        tick();
        redirect_valid = 1'b0;
        $display("txn redirect to %h (misaligned)", 32'h6);
        checks++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h6) begin errors++; $display("FAIL misalign_fault got %b/%h exp 1/6", fetch_fault, fault_pc); end
        tick(); tick();
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h6) begin errors++; $display("FAIL fault_no_fetch got %b/%h exp 0/6", if_valid, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h1000;
        tick();
        checks++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h1000) begin errors++; $display("FAIL oor_target_fault got %b/%h exp 1/1000", fetch_fault, fault_pc); end
        redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL fault_clear got %b/%b exp 0/0", fetch_fault, if_valid); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL fault_resume got %b/%h exp 1/0", if_valid, if_pc); end
    endtask

    task automatic test_end_of_mem();
        redirect_valid = 1'b1; redirect_pc = 32'hFF8; if_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h1000) begin errors++; $display("FAIL end_fault got %b/%h exp 1/1000", fetch_fault, fault_pc); end
        if_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            $display("txn drain pc=%h instr=%h", if_pc, if_instr);
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'(32'hFF8 + 4*k)) begin errors++; $display("FAIL end_drain got %b/%h exp 1/%h", if_valid, if_pc, 32'(32'hFF8 + 4*k)); end
            tick();
        end
        tick();
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h1000) begin errors++; $display("FAIL end_stop got %b/%h exp 0/1000", if_valid, imem_addr); end
    endtask

    task automatic test_halt_reset();
        do_reset();
        if_ready = 1'b1;
        tick(); tick(); tick();
        checks++; if (if_pc !== 32'h4 || imem_addr !== 32'h8) begin errors++; $display("FAIL pre_halt got %h/%h exp 4/8", if_pc, imem_addr); end
        halt_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h8) begin errors++; $display("FAIL halt_no_fetch got %b/%h exp 0/8", if_valid, imem_addr); end
        end
        reset = 1'b1;
        tick();
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h0 || fetch_fault !== 1'b0) begin errors++; $display("FAIL halt_reset got %b/%h/%b exp 0/0/0", if_valid, imem_addr, fetch_fault); end
        reset = 1'b0; halt_req = 1'b0;
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL post_reset_boot got %b exp 0", if_valid); end
        tick();
        $display("txn after reset pc=%h instr=%h", if_pc, if_instr);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h1300_0000) begin errors++; $display("FAIL post_reset_fetch got %b/%h/%h exp 1/0/13000000", if_valid, if_pc, if_instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_end_of_mem();
        test_halt_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
